ballot_unit: RTL and testbench
==============================

# ballot_unit

Voter-side ballot unit for the three-candidate voting machine (BJP, INC, JDS). It arms once per ballot issued by the presiding officer and synchronises and debounces the three raw candidate buttons. It accepts exactly one single-button vote per ballot and transmits it to the tally block as a clean high pulse on one candidate line. The tally counts on the falling edge of that pulse.

## Interface
- DB_CYCLES, 16: consecutive stable synchronised cycles required to accept a press; ≥1.
- PULSE_CYCLES, 4: width of the o_vote high pulse; ≥1.
- GAP_CYCLES, 20: minimum low time after a pulse; ≥17, to cover the tally's 16-cycle hold window.
- TIMEOUT_CYCLES, 1024: ARMED timeout; used only with BALLOT_UNIT_TIMEOUT_EN.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- i_ballot_issue  in  1  presiding-officer request to arm one ballot; level-sampled.
- i_btn  in  3  raw asynchronous buttons, active high; [0]=BJP, [1]=INC, [2]=JDS.
- i_close  in  1  voting-over; blocks new ballots.
- o_vote  out  3  one-hot vote pulse to the tally; same bit order as i_btn.
- o_ready  out  1  ballot lamp; high only in ARMED and DEBOUNCE.
- o_ballots_cast  out  16  accepted votes; saturates at 16'hFFFF.
- o_reject_cnt  out  8  multi-button rejections; saturates at 8'hFF.
- o_timeout  out  1  one-cycle pulse on ARMED timeout; tied 0 without the macro.

## Operation
- Each i_btn bit passes through a 2-flop synchroniser; all logic below uses the synchronised value, called s_btn.
- All outputs are registered.
- IDLE: o_ready=0. If i_close=1, go to CLOSED. Otherwise, if i_ballot_issue=1, go to ARMED. i_ballot_issue is ignored in every other state.
- ARMED: o_ready=1.
  - i_close=1 cancels the ballot: go to CLOSED. This has priority over button handling.
  - s_btn one-hot: latch the code, clear the debounce counter, go to DEBOUNCE.
  - s_btn has ≥2 bits set: stay in ARMED; o_reject_cnt+1 once, on the cycle the multi-bit condition first appears.
  - s_btn=0: stay.
- DEBOUNCE:
  - i_close=1: abort to CLOSED with no pulse.
  - s_btn ≠ latched code (release, change or added button): return to ARMED and clear the counter.
  - Otherwise the counter increments. When the count reaches DB_CYCLES, go to PULSE.
- PULSE: o_vote = latched code for exactly PULSE_CYCLES cycles, then go to GAP.
  - o_ballots_cast increments on entry.
  - i_close is ignored; a committed vote always completes.
- GAP: o_vote=0.
  - Leave only after GAP_CYCLES have elapsed and s_btn=0.
  - On leaving: go to CLOSED if i_close=1, else IDLE.
  - A held button therefore never produces a second vote.
- CLOSED: o_ready=0, o_vote=0. Go to IDLE when i_close=0.
- Counters saturate and never wrap. Their widths are sized from the parameters: $clog2 of the maximum value plus 1.

## Timing
- Reset, async and active-low: state goes to IDLE immediately. All outputs, counters and synchroniser flops are cleared. o_vote drops immediately, even mid-pulse.
- o_ready rises 1 cycle after i_ballot_issue is sampled in IDLE.
- Vote latency: a press first sampled at edge N appears on s_btn at edge N+2, DEBOUNCE is entered at N+3, and o_vote rises at N+3+DB_CYCLES. With defaults this is N+19.
- o_ready falls in the same cycle o_vote rises.
- Pulse width: exactly PULSE_CYCLES cycles.
- Earliest re-arm: PULSE_CYCLES+GAP_CYCLES+1 cycles after o_vote rises, provided the button is already released.
- Simultaneous i_close and a button in ARMED: i_close wins.

## Configuration
- BALLOT_UNIT_TIMEOUT_EN defined:
  - An ARMED idle counter runs only while s_btn=0 in ARMED. It clears on entering ARMED and on returning from DEBOUNCE.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, o_timeout=1 for one cycle, o_ballots_cast unchanged.
- Not defined: ARMED waits indefinitely. No timeout counter is synthesised and o_timeout is constant 0.

## Test plan
- Clean vote: use defaults. Reset, issue, then hold i_btn=3'b010 for 40 cycles. Required: o_vote=3'b010 for exactly 4 cycles starting 19 cycles after the press; o_ballots_cast=1; o_ready=0 afterward; a second issue is ignored until release plus gap.
- Bounce: issue, toggle i_btn[0] every 3 cycles for 30 cycles, then hold. Required: exactly one pulse on o_vote[0], rising DB_CYCLES+3 cycles after the last transition.
- Multi-press: issue, press 3'b101. Required: no pulse, o_reject_cnt=1. Then release and press 3'b100. Required: one pulse on o_vote[2], o_ballots_cast=1.
- Close priority:
  - i_close during DEBOUNCE: no pulse, o_ready=0, state CLOSED.
  - Repeat with i_close asserted mid-PULSE: the pulse completes its full 4 cycles.
  - Deassert i_close: IDLE.
- Async reset: assert rst=0 on the 2nd PULSE cycle. Required: o_vote=0 and o_ballots_cast=0 before the next edge; after release, state is IDLE.
- Macro on, TIMEOUT_CYCLES=1024: issue, no press. Required: o_timeout high for one cycle 1024 cycles later, o_ready=0, o_ballots_cast=0. Macro off: no timeout after 5000 cycles.

Source files
------------

// File: rtl/ballot_unit.sv
// Voter-side ballot unit: arms per issued ballot, debounces three candidate buttons, and emits one clean vote pulse.
// Optional ARMED timeout is built only when BALLOT_UNIT_TIMEOUT_EN is defined.
module ballot_unit #(
    parameter int DB_CYCLES      = 16,
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ballot_issue,
    input  logic [2:0]  i_btn,
    input  logic        i_close,
    output logic [2:0]  o_vote,
    output logic        o_ready,
    output logic [15:0] o_ballots_cast,
    output logic [7:0]  o_reject_cnt,
    output logic        o_timeout
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARMED    = 3'd1;
    localparam logic [2:0] ST_DEBOUNCE = 3'd2;
    localparam logic [2:0] ST_PULSE    = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_CLOSED   = 3'd5;

    localparam int CNT_MAX = (DB_CYCLES > PULSE_CYCLES)
                           ? ((DB_CYCLES > GAP_CYCLES) ? DB_CYCLES : GAP_CYCLES)
                           : ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]       sync_a, sync_b, s_btn;
    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       code, code_nxt;
    logic             seen, seen_nxt;
    logic             vote_inc, reject_inc;
    logic             multi, onehot;

`ifdef BALLOT_UNIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic             tmo_fire;
`endif

    // Two metastability flops plus a third stage feeding the FSM with a clean s_btn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
            s_btn  <= '0;
        end else begin
            sync_a <= i_btn;
            sync_b <= sync_a;
            s_btn  <= sync_b;
        end
    end

    assign multi  = (s_btn & (s_btn - 3'd1)) != 3'd0;
    assign onehot = (s_btn != 3'd0) && !multi;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        code_nxt   = code;
        seen_nxt   = 1'b0;
        vote_inc   = 1'b0;
        reject_inc = 1'b0;
`ifdef BALLOT_UNIT_TIMEOUT_EN
        tmo_nxt  = tmo;
        tmo_fire = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (i_close) begin
                    state_nxt = ST_CLOSED;
                end else if (i_ballot_issue) begin
                    state_nxt = ST_ARMED;
`ifdef BALLOT_UNIT_TIMEOUT_EN
                    tmo_nxt = '0;
`endif
                end
            end
            ST_ARMED: begin
                if (i_close) begin
                    state_nxt = ST_CLOSED;
                end else if (onehot) begin
                    code_nxt  = s_btn;
                    cnt_nxt   = '0;
                    state_nxt = ST_DEBOUNCE;
                end else if (multi) begin
                    // seen suppresses recounting while the same multi-press persists
                    reject_inc = !seen;
                    seen_nxt   = 1'b1;
                end else begin
`ifdef BALLOT_UNIT_TIMEOUT_EN
                    if (tmo == TMO_LAST) begin
                        state_nxt = ST_IDLE;
                        tmo_fire  = 1'b1;
                    end else begin
                        tmo_nxt = tmo + 1'b1;
                    end
`endif
                end
            end
            ST_DEBOUNCE: begin
                if (i_close) begin
                    state_nxt = ST_CLOSED;
                end else if (s_btn != code) begin
                    state_nxt = ST_ARMED;
                    cnt_nxt   = '0;
`ifdef BALLOT_UNIT_TIMEOUT_EN
                    tmo_nxt = '0;
`endif
                end else if (cnt == DB_LAST) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = '0;
                    vote_inc  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt != GAP_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (s_btn == 3'd0) begin
                    state_nxt = i_close ? ST_CLOSED : ST_IDLE;
                end
            end
            ST_CLOSED: begin
                if (!i_close) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            code           <= '0;
            seen           <= 1'b0;
            o_ready        <= 1'b0;
            o_vote         <= '0;
            o_ballots_cast <= '0;
            o_reject_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            code    <= code_nxt;
            seen    <= seen_nxt;
            o_ready <= (state_nxt == ST_ARMED) || (state_nxt == ST_DEBOUNCE);
            o_vote  <= (state_nxt == ST_PULSE) ? code_nxt : 3'd0;
            if (vote_inc && (o_ballots_cast != 16'hFFFF)) o_ballots_cast <= o_ballots_cast + 16'd1;
            if (reject_inc && (o_reject_cnt != 8'hFF))    o_reject_cnt   <= o_reject_cnt + 8'd1;
        end
    end

`ifdef BALLOT_UNIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo       <= '0;
            o_timeout <= 1'b0;
        end else begin
            tmo       <= tmo_nxt;
            o_timeout <= tmo_fire;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_unit.sv
// Directed bench for ballot_unit with default parameters (timeout macro undefined).
module tb_ballot_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue = 1'b0;
    logic        close = 1'b0;
    logic [2:0]  btn = 3'd0;
    logic [2:0]  vote;
    logic        ready;
    logic [15:0] ballots;
    logic [7:0]  rejects;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    ballot_unit dut (
        .clk            (clk),
        .rst            (rst),
        .i_ballot_issue (issue),
        .i_btn          (btn),
        .i_close        (close),
        .o_vote         (vote),
        .o_ready        (ready),
        .o_ballots_cast (ballots),
        .o_reject_cnt   (rejects),
        .o_timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; issue = 1'b0; close = 1'b0; btn = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic arm(input string tag);
        @(negedge clk);
        issue = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_on_issue"}, ready, 1'b1);
        issue = 1'b0;
    endtask

    // Runs n cycles, OR-ing o_vote/o_timeout and AND-ing o_ready across them.
    task automatic run(input int n, output logic [2:0] vote_or, output logic tmo_or,
                       output logic ready_and);
        vote_or = 3'd0; tmo_or = 1'b0; ready_and = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vote_or   = vote_or | vote;
            tmo_or    = tmo_or | timeout;
            ready_and = ready_and & ready;
        end
    endtask

    // Edges from the press-sampling edge to the edge where o_vote rises; -1 if none.
    task automatic wait_vote(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (vote != 3'd0) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    task automatic pulse_width(input logic [2:0] code, output int w);
        w = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vote == code) w++;
            else break;
        end
    endtask

    logic [2:0] v_or;
    logic       t_or, r_and;
    int         lat, w;

    initial begin
        // Reset state
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_vote", vote, 3'd0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_ballots", ballots, 16'd0);
        chk("rst_rejects", rejects, 8'd0);
        chk("rst_timeout", timeout, 1'b0);
        do_reset();

        // Clean vote on INC
        arm("clean");
        btn = 3'b010;
        wait_vote(lat);
        chk("clean_latency", lat, 19);
        chk("clean_code", vote, 3'b010);
        chk("clean_ready_fall", ready, 1'b0);
        pulse_width(3'b010, w);
        chk("clean_width", w, 4);
        chk("clean_after_vote", vote, 3'd0);
        chk("clean_ballots", ballots, 16'd1);
        issue = 1'b1;
        run(15, v_or, t_or, r_and);
        chk("clean_held_no_vote", v_or, 3'd0);
        chk("clean_held_ready_low", ready | (|v_or), 1'b0);
        btn = 3'b000;
        r_and = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready) begin r_and = 1'b1; break; end
        end
        chk("clean_rearm_after_release", r_and, 1'b1);
        issue = 1'b0;
        chk("clean_ballots_final", ballots, 16'd1);

        // Bouncing BJP button
        do_reset();
        arm("bounce");
        v_or = 3'd0;
        for (int i = 0; i < 10; i++) begin
            btn = {2'b00, (i % 2 == 0)};
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                v_or = v_or | vote;
            end
        end
        chk("bounce_no_early_vote", v_or, 3'd0);
        btn = 3'b001;
        wait_vote(lat);
        chk("bounce_latency", lat, 19);
        chk("bounce_code", vote, 3'b001);
        pulse_width(3'b001, w);
        chk("bounce_width", w, 4);
        chk("bounce_ballots", ballots, 16'd1);

        // Multi-press rejection, then a valid JDS vote
        do_reset();
        arm("multi");
        btn = 3'b101;
        run(30, v_or, t_or, r_and);
        chk("multi_no_vote", v_or, 3'd0);
        chk("multi_reject_once", rejects, 8'd1);
        chk("multi_still_ready", r_and, 1'b1);
        btn = 3'b000;
        run(5, v_or, t_or, r_and);
        btn = 3'b100;
        wait_vote(lat);
        chk("multi_latency", lat, 19);
        chk("multi_code", vote, 3'b100);
        pulse_width(3'b100, w);
        chk("multi_width", w, 4);
        chk("multi_ballots", ballots, 16'd1);
        chk("multi_reject_final", rejects, 8'd1);

        // Close during DEBOUNCE aborts the vote
        do_reset();
        arm("close_db");
        btn = 3'b010;
        run(8, v_or, t_or, r_and);
        close = 1'b1;
        run(2, v_or, t_or, r_and);
        chk("close_db_ready_low", ready, 1'b0);
        run(30, v_or, t_or, r_and);
        chk("close_db_no_vote", v_or, 3'd0);
        chk("close_db_ballots", ballots, 16'd0);
        btn = 3'b000;
        issue = 1'b1;
        run(5, v_or, t_or, r_and);
        chk("close_db_issue_blocked", ready, 1'b0);
        close = 1'b0;
        @(negedge clk);
        chk("close_db_idle_step", ready, 1'b0);
        @(negedge clk);
        chk("close_db_idle_then_armed", ready, 1'b1);
        issue = 1'b0;

        // Close mid-PULSE: vote still completes
        do_reset();
        arm("close_pulse");
        btn = 3'b010;
        wait_vote(lat);
        chk("close_pulse_latency", lat, 19);
        close = 1'b1;
        pulse_width(3'b010, w);
        chk("close_pulse_width", w, 4);
        chk("close_pulse_ballots", ballots, 16'd1);
        btn = 3'b000;
        run(30, v_or, t_or, r_and);
        chk("close_pulse_closed_ready", ready, 1'b0);
        close = 1'b0;
        issue = 1'b1;
        run(2, v_or, t_or, r_and);
        chk("close_pulse_reopen", ready, 1'b1);
        issue = 1'b0;

        // Asynchronous reset on the second PULSE cycle
        do_reset();
        arm("areset");
        btn = 3'b010;
        wait_vote(lat);
        @(negedge clk);
        chk("areset_in_pulse", vote, 3'b010);
        #1 rst = 1'b0;
        #1;
        chk("areset_vote_drop", vote, 3'd0);
        chk("areset_ballots", ballots, 16'd0);
        btn = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("areset_idle_ready", ready, 1'b0);
        arm("areset_idle");

        // No timeout without the macro
        do_reset();
        arm("no_tmo");
        run(5000, v_or, t_or, r_and);
        chk("no_tmo_pulse", t_or, 1'b0);
        chk("no_tmo_still_armed", r_and, 1'b1);
        chk("no_tmo_no_vote", v_or, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
